// File: rtl/can_bit_destuff.sv
// CAN receive-path bit destuffer: removes stuff bits, flags stuff errors and
// runs CRC-15 over the destuffed stream handed to the frame decoder.
module can_bit_destuff #(
    parameter int unsigned           STUFF_LEN = 5,
    parameter int unsigned           CRC_WIDTH = 15,
    parameter logic [CRC_WIDTH-1:0]  CRC_POLY  = 15'h4599
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_point,
    input  logic                 sampled_bit,
    input  logic                 stuff_en,
    input  logic                 crc_en,
    input  logic                 crc_init,
    input  logic                 go_error_frame,
    output logic                 rx_bit_valid,
    output logic                 rx_bit,
    output logic                 stuff_drop,
    output logic                 stuff_err,
    output logic [CRC_WIDTH-1:0] crc_reg,
    output logic                 crc_zero
);

    localparam int unsigned      RUN_W   = 3;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
    logic                 last_bit_q, last_bit_d;
    logic                 rx_bit_valid_q, rx_bit_valid_d;
    logic                 rx_bit_q, rx_bit_d;
    logic                 stuff_drop_q, stuff_drop_d;
    logic                 stuff_err_q, stuff_err_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic                 stuff_pend_c;
    logic                 crc_fb_c;

    assign stuff_pend_c = (run_cnt_q == RUN_MAX);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            run_cnt_q      <= '0;
            last_bit_q     <= 1'b1;
            rx_bit_valid_q <= 1'b0;
            rx_bit_q       <= 1'b0;
            stuff_drop_q   <= 1'b0;
            stuff_err_q    <= 1'b0;
            crc_q          <= '0;
        end else begin
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            last_bit_q     <= last_bit_d;
            rx_bit_valid_q <= rx_bit_valid_d;
            rx_bit_q       <= rx_bit_d;
            stuff_drop_q   <= stuff_drop_d;
            stuff_err_q    <= stuff_err_d;
            crc_q          <= crc_d;
        end
    end

    // Next-state, run tracking and pulse generation
    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        last_bit_d     = last_bit_q;
        rx_bit_valid_d = 1'b0;
        rx_bit_d       = 1'b0;
        stuff_drop_d   = 1'b0;
        stuff_err_d    = 1'b0;

        if (go_error_frame) begin
            state_d   = ST_IDLE;
            run_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (stuff_en) begin
                        // Entry bit is handled as the first bit of a fresh run
                        state_d   = ST_ACTIVE;
                        run_cnt_d = '0;
                        if (sample_point) begin
                            rx_bit_valid_d = 1'b1;
                            rx_bit_d       = sampled_bit;
                            run_cnt_d      = RUN_W'(1);
                            last_bit_d     = sampled_bit;
                        end
                    end else if (sample_point) begin
                        rx_bit_valid_d = 1'b1;
                        rx_bit_d       = sampled_bit;
                        last_bit_d     = sampled_bit;
                    end
                end

                ST_ACTIVE: begin
                    if (sample_point) begin
                        if (stuff_pend_c && (sampled_bit != last_bit_q)) begin
                            stuff_drop_d = 1'b1;
                            run_cnt_d    = RUN_W'(1);
                            last_bit_d   = sampled_bit;
                        end else if (stuff_pend_c) begin
                            stuff_err_d = 1'b1;
                            state_d     = ST_ERR;
                        end else begin
                            rx_bit_valid_d = 1'b1;
                            rx_bit_d       = sampled_bit;
                            run_cnt_d      = ((run_cnt_q != '0) && (sampled_bit == last_bit_q))
                                           ? run_cnt_q + RUN_W'(1) : RUN_W'(1);
                            last_bit_d     = sampled_bit;
                        end
                        if (!stuff_en && !stuff_err_d) begin
                            state_d   = ST_IDLE;
                            run_cnt_d = '0;
                        end
                    end else if (!stuff_en && !stuff_pend_c) begin
                        // A pending stuff bit keeps us here until it is checked
                        state_d   = ST_IDLE;
                        run_cnt_d = '0;
                    end
                end

                ST_ERR: begin
                    if (sample_point) begin
                        last_bit_d = sampled_bit;
                    end
                    if (!stuff_en) begin
                        state_d   = ST_IDLE;
                        run_cnt_d = '0;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    run_cnt_d = '0;
                end
            endcase
        end
    end

    // CRC-15 over emitted bits; crc_init wins over a same-cycle update
    assign crc_fb_c = rx_bit_d ^ crc_q[CRC_WIDTH-1];

    always_comb begin
        crc_d = crc_q;
        if (crc_init) begin
            crc_d = '0;
        end else if (rx_bit_valid_d && crc_en) begin
            crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (crc_fb_c ? CRC_POLY : CRC_WIDTH'(0));
        end
    end

    assign rx_bit_valid = rx_bit_valid_q;
    assign rx_bit       = rx_bit_q;
    assign stuff_drop   = stuff_drop_q;
    assign stuff_err    = stuff_err_q;
    assign crc_reg      = crc_q;
    assign crc_zero     = (crc_q == '0);

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed self-checking bench for can_bit_destuff.
module tb_can_bit_destuff;

    localparam logic [3:0] V0   = 4'b1000;
    localparam logic [3:0] V1   = 4'b1100;
    localparam logic [3:0] DROP = 4'b0010;
    localparam logic [3:0] ERRP = 4'b0001;
    localparam logic [3:0] NONE = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_point;
    logic        sampled_bit;
    logic        stuff_en;
    logic        crc_en;
    logic        crc_init;
    logic        go_error_frame;
    logic        rx_bit_valid;
    logic        rx_bit;
    logic        stuff_drop;
    logic        stuff_err;
    logic [14:0] crc_reg;
    logic        crc_zero;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    always #5 clk = ~clk;

    can_bit_destuff dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_point   (sample_point),
        .sampled_bit    (sampled_bit),
        .stuff_en       (stuff_en),
        .crc_en         (crc_en),
        .crc_init       (crc_init),
        .go_error_frame (go_error_frame),
        .rx_bit_valid   (rx_bit_valid),
        .rx_bit         (rx_bit),
        .stuff_drop     (stuff_drop),
        .stuff_err      (stuff_err),
        .crc_reg        (crc_reg),
        .crc_zero       (crc_zero)
    );

    function automatic logic [3:0] vexp(input logic b);
        return b ? V1 : V0;
    endfunction

    // Present one bit and capture {valid, bit, drop, err} one clock later
    task automatic send(input logic b, output logic [3:0] o);
        @(negedge clk);
        sample_point = 1'b1;
        sampled_bit  = b;
        @(posedge clk);
        #1;
        sample_point = 1'b0;
        o = {rx_bit_valid, rx_bit_valid & rx_bit, stuff_drop, stuff_err};
    endtask

    task automatic to_idle;
        @(negedge clk);
        go_error_frame = 1'b1;
        stuff_en       = 1'b0;
        crc_en         = 1'b0;
        @(negedge clk);
        go_error_frame = 1'b0;
    endtask

    task automatic pulse_crc_init;
        @(negedge clk);
        crc_init = 1'b1;
        @(negedge clk);
        crc_init = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({rx_bit_valid, rx_bit, stuff_drop, stuff_err, crc_reg} !== 19'h0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_bit_valid, rx_bit, stuff_drop, stuff_err, crc_reg});
        end else pass_cnt++;
        chk_cnt++;
        if (crc_zero !== 1'b1) $display("FAIL reset_crc_zero: got %b expected 1", crc_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_passthrough;
        logic [3:0] o;
        logic sb [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        to_idle();
        for (int i = 0; i < 7; i++) begin
            send(sb[i], o);
            chk_cnt++;
            if (o !== vexp(sb[i])) $display("FAIL idle_pass[%0d]: got %b expected %b", i, o, vexp(sb[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_destuff;
        logic [3:0] o;
        logic sb [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] ex [11] = '{V0, V0, V0, V0, V0, DROP, V1, V1, V1, V1, DROP};
        to_idle();
        stuff_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send(sb[i], o);
            chk_cnt++;
            if (o !== ex[i]) $display("FAIL destuff[%0d]: got %b expected %b", i, o, ex[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stuff_err;
        logic [3:0] o;
        logic sb [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] ex [9] = '{V1, V1, V1, V1, V1, ERRP, NONE, NONE, NONE};
        to_idle();
        stuff_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(sb[i], o);
            chk_cnt++;
            if (o !== ex[i]) $display("FAIL stuff_err[%0d]: got %b expected %b", i, o, ex[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        go_error_frame = 1'b1;
        @(negedge clk);
        go_error_frame = 1'b0;
        send(1'b1, o);
        chk_cnt++;
        if (o !== V1) $display("FAIL err_recover: got %b expected %b", o, V1);
        else pass_cnt++;
    endtask

    task automatic test_crc;
        logic [3:0]  o;
        logic [14:0] cw = 15'h4EAB;
        to_idle();
        crc_en   = 1'b1;
        stuff_en = 1'b1;
        pulse_crc_init();
        send(1'b1, o);
        chk_cnt++;
        if (crc_reg !== 15'h4599) $display("FAIL crc_bit1: got %h expected 4599", crc_reg);
        else pass_cnt++;
        send(1'b0, o);
        chk_cnt++;
        if (crc_reg !== 15'h4EAB) $display("FAIL crc_bit2: got %h expected 4eab", crc_reg);
        else pass_cnt++;
        for (int i = 14; i >= 0; i--) begin
            send(cw[i], o);
            chk_cnt++;
            if (o !== vexp(cw[i])) $display("FAIL crc_fold[%0d]: got %b expected %b", i, o, vexp(cw[i]));
            else pass_cnt++;
        end
        chk_cnt++;
        if (crc_reg !== 15'h0) $display("FAIL crc_residue: got %h expected 0", crc_reg);
        else pass_cnt++;
        chk_cnt++;
        if (crc_zero !== 1'b1) $display("FAIL crc_zero: got %b expected 1", crc_zero);
        else pass_cnt++;
        crc_en = 1'b0;
        send(1'b1, o);
        chk_cnt++;
        if ({o, crc_reg} !== {V1, 15'h0}) $display("FAIL crc_hold: got %h expected %h", {o, crc_reg}, {V1, 15'h0});
        else pass_cnt++;
        crc_en = 1'b1;
        send(1'b1, o);
        chk_cnt++;
        if (crc_reg !== 15'h4599) $display("FAIL crc_resume: got %h expected 4599", crc_reg);
        else pass_cnt++;
        crc_init = 1'b1;
        send(1'b0, o);
        crc_init = 1'b0;
        chk_cnt++;
        if ({o, crc_reg} !== {V0, 15'h0}) $display("FAIL crc_init_override: got %h expected %h", {o, crc_reg}, {V0, 15'h0});
        else pass_cnt++;
    endtask

    task automatic test_stuff_in_crc;
        logic [3:0] o;
        to_idle();
        crc_en   = 1'b1;
        stuff_en = 1'b1;
        pulse_crc_init();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, o);
            chk_cnt++;
            if (o !== V1) $display("FAIL crc_stuff_run[%0d]: got %b expected %b", i, o, V1);
            else pass_cnt++;
        end
        chk_cnt++;
        if (crc_reg !== 15'h0A6D) $display("FAIL crc_before_drop: got %h expected 0a6d", crc_reg);
        else pass_cnt++;
        send(1'b0, o);
        chk_cnt++;
        if ({o, crc_reg} !== {DROP, 15'h0A6D}) $display("FAIL crc_at_drop: got %h expected %h", {o, crc_reg}, {DROP, 15'h0A6D});
        else pass_cnt++;
    endtask

    task automatic test_gef_collide;
        logic [3:0] o;
        to_idle();
        stuff_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, o);
            chk_cnt++;
            if (o !== V0) $display("FAIL gef_pre[%0d]: got %b expected %b", i, o, V0);
            else pass_cnt++;
        end
        go_error_frame = 1'b1;
        send(1'b0, o);
        go_error_frame = 1'b0;
        chk_cnt++;
        if (o !== NONE) $display("FAIL gef_collide: got %b expected %b", o, NONE);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            send(i == 5, o);
            chk_cnt++;
            if (o !== ((i == 5) ? DROP : V0)) $display("FAIL gef_post[%0d]: got %b expected %b", i, o, (i == 5) ? DROP : V0);
            else pass_cnt++;
        end
    endtask

    task automatic test_pending_at_fall;
        logic [3:0] o;
        to_idle();
        stuff_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, o);
            chk_cnt++;
            if (o !== V0) $display("FAIL pend_run[%0d]: got %b expected %b", i, o, V0);
            else pass_cnt++;
        end
        @(negedge clk);
        stuff_en = 1'b0;
        repeat (2) @(negedge clk);
        send(1'b1, o);
        chk_cnt++;
        if (o !== DROP) $display("FAIL pend_drop: got %b expected %b", o, DROP);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, o);
            chk_cnt++;
            if (o !== V0) $display("FAIL pend_idle[%0d]: got %b expected %b", i, o, V0);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] o;
        to_idle();
        crc_en   = 1'b1;
        stuff_en = 1'b1;
        pulse_crc_init();
        for (int i = 0; i < 4; i++) send(1'b1, o);
        chk_cnt++;
        if (crc_reg !== 15'h27FA) $display("FAIL rst_pre_crc: got %h expected 27fa", crc_reg);
        else pass_cnt++;
        @(negedge clk);
        rst_n        = 1'b0;
        sample_point = 1'b1;
        sampled_bit  = 1'b1;
        @(posedge clk);
        #1;
        sample_point = 1'b0;
        chk_cnt++;
        if ({rx_bit_valid, rx_bit, stuff_drop, stuff_err, crc_reg} !== 19'h0) begin
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {rx_bit_valid, rx_bit, stuff_drop, stuff_err, crc_reg});
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(i != 5, o);
            chk_cnt++;
            if (o !== ((i == 5) ? DROP : V1)) $display("FAIL rst_post[%0d]: got %b expected %b", i, o, (i == 5) ? DROP : V1);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        sample_point   = 1'b0;
        sampled_bit    = 1'b1;
        stuff_en       = 1'b0;
        crc_en         = 1'b0;
        crc_init       = 1'b0;
        go_error_frame = 1'b0;

        test_reset();
        test_idle_passthrough();
        test_destuff();
        test_stuff_err();
        test_crc();
        test_stuff_in_crc();
        test_gef_collide();
        test_pending_at_fall();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
